load_unit: RTL and testbench
============================

LOAD_UNIT -- requirements
Module: load_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum cycles in REQ awaiting bus_ack; used only when LOAD_TIMEOUT_EN is defined.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  reset; asynchronous, active-high.
REQ-004 start  input  1  load request; sampled only in IDLE.
REQ-005 op  input  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu; 101-111 illegal.
REQ-006 addr  input  32  byte address of the load; sampled with start.
REQ-007 busy  output  1  high whenever state is not IDLE.
REQ-008 bus_req  output  1  memory read request; high throughout REQ.
REQ-009 bus_addr  output  32  word address {addr_q[31:2],2'b00}; held stable while bus_req is high.
REQ-010 bus_ack  input  1  memory response; bus_rdata is valid in the same cycle.
REQ-011 bus_rdata  input  32  memory read word, little-endian byte lanes.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 rdata  output  32  extended load result; valid when done is high, held until the next completion.
REQ-014 err  output  1  high together with done when the load faulted; rdata is 0 in that case.

Function
REQ-015 FSM states IDLE, REQ, DONE.
REQ-016 IDLE + start: latch op_q and addr_q. Legal, aligned load -> REQ. Illegal op or misaligned address -> DONE with err.
REQ-017 Misalignment rules: lw requires addr[1:0]==00; lh/lhu require addr[0]==0; lb/lbu are always aligned.
REQ-018 A faulted request never asserts bus_req.
REQ-019 REQ: bus_req=1. On bus_ack, register the extracted result and go to DONE. Without bus_ack, stay in REQ.
REQ-020 DONE: done=1 for exactly one cycle, then IDLE. start is ignored in DONE.
REQ-021 Minimum latency for a legal load: start sampled at edge N, bus_req high in cycle N+1; if bus_ack arrives in N+1, done is high in cycle N+2.
REQ-022 Extraction, with A=addr_q[1:0]:
  - lw: whole word.
  - lh/lhu: bus_rdata[15:0] if A[1]==0, else [31:16].
  - lb/lbu: byte lane A (A=00 -> [7:0] ... A=11 -> [31:24]).
REQ-023 lh and lb sign-extend to 32 bits; lhu and lbu zero-extend.
REQ-024 start while busy is high is ignored and is not queued.
REQ-025 bus_ack outside REQ is ignored.
REQ-026 Changes on addr or op while busy do not affect the operation in flight.

Reset
REQ-027 Reset forces state=IDLE and busy=0, bus_req=0, bus_addr=0, done=0, err=0, rdata=0, op_q=0, addr_q=0, timeout counter=0.
REQ-028 Reset mid-operation, including REQ with bus_req high, aborts immediately with no done pulse; the first start after reset deasserts is accepted normally.

Configuration
REQ-029 Macro LOAD_TIMEOUT_EN.
REQ-030 Defined: a counter clears on entry to REQ and increments each REQ cycle without bus_ack. When it reaches TIMEOUT_CYCLES without ack, the unit goes to DONE with err=1 and rdata=0, and bus_req drops. An ack in the same cycle the limit is reached wins and completes normally.
REQ-031 Not defined: no counter is built, and REQ waits for bus_ack indefinitely.

Verification
REQ-032 lb: op=011, addr=0x1003, bus_rdata=0x80FF1234, ack in first REQ cycle -> done two cycles after start, rdata=0xFFFFFF80, err=0, bus_addr=0x1000.
REQ-033 lhu: op=010, addr=0x2002, bus_rdata=0x9ABC0001 -> rdata=0x00009ABC. Same data with lh (op=001) -> rdata=0xFFFF9ABC.
REQ-034 Misaligned lw: op=000, addr=0x3001 -> bus_req never rises, done+err one cycle after the start edge, rdata=0.
REQ-035 Ack delayed 5 cycles, with start pulsed during the wait -> bus_req high for 5 cycles, exactly one done, second start dropped.
REQ-036 Reset asserted during REQ -> all outputs 0 in the same cycle, no done; a new lw at 0x0 then completes normally.
REQ-037 LOAD_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, no ack -> bus_req high for 4 cycles, then done=1, err=1, rdata=0.

Source files
------------

// File: rtl/load_unit.sv
// load_unit: single-outstanding load unit.
//   Accepts a load request (lw/lh/lhu/lb/lbu) in IDLE, checks the opcode and
//   alignment, issues one word read on the memory bus, then extracts and
//   extends the addressed byte/halfword into rdata with a one-cycle done pulse.
//   Faulted requests (illegal op or misaligned address) never touch the bus
//   and complete with err=1 and rdata=0.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start, op, addr       request (sampled only in IDLE)
//   busy                  high whenever the unit is not IDLE
//   bus_req, bus_addr     word-aligned read request, held for the whole REQ state
//   bus_ack, bus_rdata    read response, data valid with ack
//   done, rdata, err      completion pulse, extended result (held), fault flag
//
// Build option:
//   LOAD_TIMEOUT_EN  when defined, REQ gives up after TIMEOUT_CYCLES cycles
//                    without bus_ack and completes with err=1 (TIMEOUT_CYCLES >= 1).
module load_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  output logic        busy,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        fault;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;
  logic [31:0] extracted;
  logic        timeout_hit;

`ifdef LOAD_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  // Counter is held at zero outside REQ, so it is cleared on every entry to REQ.
  always_comb begin
    cnt_d = '0;
    if (state_q == S_REQ) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // cnt_q counts completed ack-less REQ cycles; the limit is reached at the end
  // of the cycle where it reads TIMEOUT_CYCLES-1. An ack in that cycle wins.
  assign timeout_hit = (state_q == S_REQ) && !bus_ack &&
                       (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  logic [31:0] timeout_cfg_unused;
  assign timeout_cfg_unused = TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
`endif

  // Request legality, evaluated on the incoming op/addr.
  always_comb begin
    case (op)
      3'd0:       fault = (addr[1:0] != 2'b00);
      3'd1, 3'd2: fault = addr[0];
      3'd3, 3'd4: fault = 1'b0;
      default:    fault = 1'b1;
    endcase
  end

  // Lane selection and extension from the latched op/address.
  always_comb begin
    half_sel = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (addr_q[1:0])
      2'b00:   byte_sel = bus_rdata[7:0];
      2'b01:   byte_sel = bus_rdata[15:8];
      2'b10:   byte_sel = bus_rdata[23:16];
      default: byte_sel = bus_rdata[31:24];
    endcase
    case (op_q)
      3'd0:    extracted = bus_rdata;
      3'd1:    extracted = {{16{half_sel[15]}}, half_sel};
      3'd2:    extracted = {16'h0000, half_sel};
      3'd3:    extracted = {{24{byte_sel[7]}}, byte_sel};
      3'd4:    extracted = {24'h000000, byte_sel};
      default: extracted = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      op_q    <= op_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next state and datapath updates.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d   = op;
          addr_d = addr;
          if (fault) begin
            state_d = S_DONE;
            rdata_d = '0;
            err_d   = 1'b1;
          end else begin
            state_d = S_REQ;
            err_d   = 1'b0;
          end
        end
      end
      S_REQ: begin
        if (bus_ack) begin
          state_d = S_DONE;
          rdata_d = extracted;
          err_d   = 1'b0;
        end else if (timeout_hit) begin
          state_d = S_DONE;
          rdata_d = '0;
          err_d   = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    busy     = (state_q != S_IDLE);
    bus_req  = (state_q == S_REQ);
    bus_addr = {addr_q[31:2], 2'b00};
    done     = (state_q == S_DONE);
    err      = (state_q == S_DONE) && err_q;
    rdata    = rdata_q;
  end

endmodule

// File: tb/tb_load_unit.sv
module tb_load_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] addr;
  logic        busy;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        done;
  logic [31:0] rdata;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef LOAD_TIMEOUT_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 255;
`endif

  load_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .addr      (addr),
    .busy      (busy),
    .bus_req   (bus_req),
    .bus_addr  (bus_addr),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata),
    .done      (done),
    .rdata     (rdata),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one load; ack on the ack_at-th bus_req cycle (0 = never), pulse start
  // again in cycle start_at after the accepting edge (0 = never).
  // lat = cycle (after the start edge) in which done was seen, -1 if never.
  // pb/pd = busy/done seen in the two cycles following done.
  task automatic run_load(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                          input int ack_at, input int start_at,
                          output int lat, output int nreq, output logic [31:0] rd,
                          output logic e, output logic [31:0] ba,
                          output logic pb, output logic pd);
    lat = -1; nreq = 0; rd = '0; e = 1'b0; ba = '0; pb = 1'b0; pd = 1'b0;
    start = 1'b1; op = o; addr = a;
    step();
    start = 1'b0; op = 3'b111; addr = '1;
    for (int c = 1; c <= 60; c++) begin
      start = (c == start_at);
      if (done) begin
        lat = c; rd = rdata; e = err;
        break;
      end
      if (bus_req) begin
        nreq++;
        ba = bus_addr;
        if (nreq == ack_at) begin
          bus_ack = 1'b1;
          bus_rdata = d;
        end
      end
      step();
      bus_ack = 1'b0;
      bus_rdata = 32'h5A5A_5A5A;
    end
    step();
    start = 1'b0;
    pb = busy; pd = done;
    step();
    pb = pb | busy; pd = pd | done;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = '0; addr = '0; bus_ack = 1'b0; bus_rdata = '0;
    repeat (2) step();
    n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (bus_req !== 1'b0)  begin n_bad++; $display("FAIL reset_bus_req: got %b want 0", bus_req); end
    n_cmp++; if (bus_addr !== '0)   begin n_bad++; $display("FAIL reset_bus_addr: got %h want 0", bus_addr); end
    n_cmp++; if (done !== 1'b0)     begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (err !== 1'b0)      begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
    n_cmp++; if (rdata !== '0)      begin n_bad++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_lb();
    int lat, nreq; logic [31:0] rd, ba; logic e, pb, pd;
    run_load(3'b011, 32'h0000_1003, 32'h80FF_1234, 1, 0, lat, nreq, rd, e, ba, pb, pd);
    n_cmp++; if (lat !== 2)             begin n_bad++; $display("FAIL lb_latency: got %0d want 2", lat); end
    n_cmp++; if (nreq !== 1)            begin n_bad++; $display("FAIL lb_req_cycles: got %0d want 1", nreq); end
    n_cmp++; if (rd !== 32'hFFFF_FF80)  begin n_bad++; $display("FAIL lb_rdata: got %h want ffffff80", rd); end
    n_cmp++; if (e !== 1'b0)            begin n_bad++; $display("FAIL lb_err: got %b want 0", e); end
    n_cmp++; if (ba !== 32'h0000_1000)  begin n_bad++; $display("FAIL lb_bus_addr: got %h want 00001000", ba); end
    n_cmp++; if (pd !== 1'b0)           begin n_bad++; $display("FAIL lb_single_done: got %b want 0", pd); end
    n_cmp++; if (rdata !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb_rdata_held: got %h want ffffff80", rdata); end
  endtask

  task automatic test_halfword();
    logic [2:0]  t_op[4]   = '{3'd2, 3'd1, 3'd1, 3'd2};
    logic [31:0] t_addr[4] = '{32'h2002, 32'h2002, 32'h2000, 32'h2000};
    logic [31:0] t_dat[4]  = '{32'h9ABC_0001, 32'h9ABC_0001, 32'h1234_8001, 32'h1234_8001};
    logic [31:0] t_exp[4]  = '{32'h0000_9ABC, 32'hFFFF_9ABC, 32'hFFFF_8001, 32'h0000_8001};
    int lat, nreq; logic [31:0] rd, ba; logic e, pb, pd;
    for (int unsigned i = 0; i < 4; i++) begin
      run_load(t_op[i], t_addr[i], t_dat[i], 1, 0, lat, nreq, rd, e, ba, pb, pd);
      n_cmp++; if (rd !== t_exp[i]) begin n_bad++; $display("FAIL half_rdata[%0d]: got %h want %h", i, rd, t_exp[i]); end
      n_cmp++; if (ba !== 32'h2000) begin n_bad++; $display("FAIL half_bus_addr[%0d]: got %h want 00002000", i, ba); end
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] exp_u[4] = '{32'h15, 32'hC3, 32'h7F, 32'h80};
    logic [31:0] exp_s[4] = '{32'h15, 32'hFFFF_FFC3, 32'h7F, 32'hFFFF_FF80};
    int lat, nreq; logic [31:0] rd, ba; logic e, pb, pd;
    for (int unsigned i = 0; i < 4; i++) begin
      run_load(3'd4, 32'h10 + i, 32'h807F_C315, 1, 0, lat, nreq, rd, e, ba, pb, pd);
      n_cmp++; if (rd !== exp_u[i]) begin n_bad++; $display("FAIL lbu_lane[%0d]: got %h want %h", i, rd, exp_u[i]); end
      run_load(3'd3, 32'h10 + i, 32'h807F_C315, 1, 0, lat, nreq, rd, e, ba, pb, pd);
      n_cmp++; if (rd !== exp_s[i]) begin n_bad++; $display("FAIL lb_lane[%0d]: got %h want %h", i, rd, exp_s[i]); end
    end
  endtask

  task automatic test_word();
    int lat, nreq; logic [31:0] rd, ba; logic e, pb, pd;
    run_load(3'd0, 32'h0000_0100, 32'hCAFE_F00D, 1, 0, lat, nreq, rd, e, ba, pb, pd);
    n_cmp++; if (lat !== 2)            begin n_bad++; $display("FAIL lw_latency: got %0d want 2", lat); end
    n_cmp++; if (rd !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL lw_rdata: got %h want cafef00d", rd); end
  endtask

  task automatic test_fault();
    logic [2:0]  t_op[6]   = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd5, 3'd7};
    logic [31:0] t_addr[6] = '{32'h3001, 32'h3002, 32'h2001, 32'h2003, 32'h0, 32'h4};
    int lat, nreq; logic [31:0] rd, ba; logic e, pb, pd;
    for (int unsigned i = 0; i < 6; i++) begin
      run_load(t_op[i], t_addr[i], 32'hFFFF_FFFF, 1, 0, lat, nreq, rd, e, ba, pb, pd);
      n_cmp++; if (lat !== 1)   begin n_bad++; $display("FAIL fault_latency[%0d]: got %0d want 1", i, lat); end
      n_cmp++; if (nreq !== 0)  begin n_bad++; $display("FAIL fault_bus_req[%0d]: got %0d cycles want 0", i, nreq); end
      n_cmp++; if (e !== 1'b1)  begin n_bad++; $display("FAIL fault_err[%0d]: got %b want 1", i, e); end
      n_cmp++; if (rd !== '0)   begin n_bad++; $display("FAIL fault_rdata[%0d]: got %h want 0", i, rd); end
    end
  endtask

  task automatic test_back_to_back();
    int lat, nreq; logic [31:0] rd, ba; logic e, pb, pd;
    run_load(3'd0, 32'h40, 32'h1122_3344, 5, 3, lat, nreq, rd, e, ba, pb, pd);
    n_cmp++; if (nreq !== 5)            begin n_bad++; $display("FAIL b2b_req_cycles: got %0d want 5", nreq); end
    n_cmp++; if (lat !== 6)             begin n_bad++; $display("FAIL b2b_latency: got %0d want 6", lat); end
    n_cmp++; if (rd !== 32'h1122_3344)  begin n_bad++; $display("FAIL b2b_rdata: got %h want 11223344", rd); end
    n_cmp++; if (e !== 1'b0)            begin n_bad++; $display("FAIL b2b_err: got %b want 0", e); end
    n_cmp++; if (pb !== 1'b0)           begin n_bad++; $display("FAIL b2b_dropped_start: busy %b want 0", pb); end
    n_cmp++; if (pd !== 1'b0)           begin n_bad++; $display("FAIL b2b_extra_done: got %b want 0", pd); end
    run_load(3'd4, 32'h41, 32'h0000_AA00, 1, 2, lat, nreq, rd, e, ba, pb, pd);
    n_cmp++; if (rd !== 32'h0000_00AA)  begin n_bad++; $display("FAIL done_start_rdata: got %h want 000000aa", rd); end
    n_cmp++; if (pb !== 1'b0)           begin n_bad++; $display("FAIL done_start_ignored: busy %b want 0", pb); end
  endtask

  task automatic test_ack_outside();
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    repeat (3) step();
    bus_ack = 1'b0;
    n_cmp++; if (busy !== 1'b0)         begin n_bad++; $display("FAIL idle_ack_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0)         begin n_bad++; $display("FAIL idle_ack_done: got %b want 0", done); end
    n_cmp++; if (rdata !== 32'h0000_00AA) begin n_bad++; $display("FAIL idle_ack_rdata: got %h want 000000aa", rdata); end
  endtask

  task automatic test_reset_mid();
    int lat, nreq; logic [31:0] rd, ba; logic e, pb, pd, seen_done;
    start = 1'b1; op = 3'd0; addr = 32'h0000_0008;
    step();
    start = 1'b0;
    n_cmp++; if (bus_req !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre_req: got %b want 1", bus_req); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if ({busy, bus_req, done, err} !== 4'b0000) begin n_bad++; $display("FAIL rstmid_flags: got %b want 0000", {busy, bus_req, done, err}); end
    n_cmp++; if (bus_addr !== '0) begin n_bad++; $display("FAIL rstmid_bus_addr: got %h want 0", bus_addr); end
    n_cmp++; if (rdata !== '0)    begin n_bad++; $display("FAIL rstmid_rdata: got %h want 0", rdata); end
    bus_ack = 1'b1;
    seen_done = 1'b0;
    repeat (2) begin step(); seen_done = seen_done | done; end
    bus_ack = 1'b0;
    reset = 1'b0;
    step();
    seen_done = seen_done | done;
    n_cmp++; if (seen_done !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_done: got %b want 0", seen_done); end
    run_load(3'd0, 32'h0, 32'hDEAD_BEEF, 1, 0, lat, nreq, rd, e, ba, pb, pd);
    n_cmp++; if (lat !== 2)            begin n_bad++; $display("FAIL rstmid_after_latency: got %0d want 2", lat); end
    n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rstmid_after_rdata: got %h want deadbeef", rd); end
  endtask

  task automatic test_wait_limit();
    int lat, nreq; logic [31:0] rd, ba; logic e, pb, pd;
`ifdef LOAD_TIMEOUT_EN
    run_load(3'd0, 32'h50, 32'h1234_5678, 0, 0, lat, nreq, rd, e, ba, pb, pd);
    n_cmp++; if (nreq !== 4)  begin n_bad++; $display("FAIL timeout_req_cycles: got %0d want 4", nreq); end
    n_cmp++; if (lat !== 5)   begin n_bad++; $display("FAIL timeout_latency: got %0d want 5", lat); end
    n_cmp++; if (e !== 1'b1)  begin n_bad++; $display("FAIL timeout_err: got %b want 1", e); end
    n_cmp++; if (rd !== '0)   begin n_bad++; $display("FAIL timeout_rdata: got %h want 0", rd); end
    run_load(3'd0, 32'h50, 32'h1234_5678, 4, 0, lat, nreq, rd, e, ba, pb, pd);
    n_cmp++; if (e !== 1'b0)           begin n_bad++; $display("FAIL limit_ack_err: got %b want 0", e); end
    n_cmp++; if (rd !== 32'h1234_5678) begin n_bad++; $display("FAIL limit_ack_rdata: got %h want 12345678", rd); end
`else
    run_load(3'd0, 32'h50, 32'h1234_5678, 20, 0, lat, nreq, rd, e, ba, pb, pd);
    n_cmp++; if (nreq !== 20)          begin n_bad++; $display("FAIL longwait_req_cycles: got %0d want 20", nreq); end
    n_cmp++; if (lat !== 21)           begin n_bad++; $display("FAIL longwait_latency: got %0d want 21", lat); end
    n_cmp++; if (e !== 1'b0)           begin n_bad++; $display("FAIL longwait_err: got %b want 0", e); end
    n_cmp++; if (rd !== 32'h1234_5678) begin n_bad++; $display("FAIL longwait_rdata: got %h want 12345678", rd); end
`endif
  endtask

  initial begin
    test_reset();
    test_lb();
    test_halfword();
    test_byte_lanes();
    test_word();
    test_fault();
    test_back_to_back();
    test_ack_outside();
    test_reset_mid();
    test_wait_limit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule
